// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART transmitter: FSM state encoding,
// parity mode selectors and the default divisor width.
package uart_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-time down-counter. o_tick is high on the last cycle of every
// i_div-cycle period; i_load restarts the period. o_tick_next_c tells the
// owner whether the following cycle will carry a tick.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_tick_next_c
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic [DIV_W-1:0] w_reload;
    logic [DIV_W-1:0] w_cnt_next;

    // i_div is never 0 here, so the reload value cannot wrap
    assign w_reload = i_div - DIV_W'(1);

    // Next count: reload on restart or at the end of a period, else count down
    always_comb begin
        w_cnt_next = r_cnt - DIV_W'(1);
        if (i_load || (r_cnt == '0)) begin
            w_cnt_next = w_reload;
        end
    end

    assign o_tick_next_c = (w_cnt_next == '0);
    assign o_tick        = r_tick;

    // Counter and registered tick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= o_tick_next_c;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with compile-time frame format and a runtime divisor.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN,
// which adds the brk input and the BREAK state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIV_W     = DIV_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     clks_per_bit,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par;
    logic [DIV_W-1:0]     r_div;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_brk_mark;

    logic             w_brk;
    logic             w_accept;
    logic             w_brk_release;
    logic             w_load;
    logic             w_tick;
    logic             w_tick_next;
    logic             w_enter_stop;
    logic             w_last_stop_next;
    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W-1:0] w_div_sel;

`ifdef UART_TX_BREAK_EN
    assign w_brk = brk;
`else
    assign w_brk = 1'b0;
`endif

    assign in_ready      = (r_state == S_IDLE) & ~rst & ~w_brk;
    assign w_accept      = in_valid & in_ready;
    assign w_brk_release = (r_state == S_BREAK) & ~r_brk_mark & ~w_brk;
    assign w_load        = w_accept | w_brk_release;
    assign w_div_eff     = (clks_per_bit == '0) ? DIV_W'(1) : clks_per_bit;
    assign w_div_sel     = w_accept ? w_div_eff : r_div;

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load       (w_load),
        .i_div        (w_div_sel),
        .o_tick       (w_tick),
        .o_tick_next_c(w_tick_next)
    );

    // Look ahead: will the next cycle sit inside the final stop bit?
    always_comb begin
        w_enter_stop     = 1'b0;
        w_last_stop_next = 1'b0;
        if (w_tick) begin
            if ((r_state == S_DATA) && (r_bit_idx == IDX_W'(DATA_BITS - 1)) &&
                (PARITY == PAR_NONE)) begin
                w_enter_stop = 1'b1;
            end
            if (r_state == S_PARITY) begin
                w_enter_stop = 1'b1;
            end
        end
        if (w_enter_stop && (STOP_BITS == 1)) begin
            w_last_stop_next = 1'b1;
        end
        if (r_state == S_STOP) begin
            if (!w_tick && (r_stop_idx == 1'(STOP_BITS - 1))) begin
                w_last_stop_next = 1'b1;
            end
            if (w_tick && (STOP_BITS == 2) && (r_stop_idx == 1'b0)) begin
                w_last_stop_next = 1'b1;
            end
        end
    end

    // Frame FSM, shifter and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_par        <= 1'b0;
            r_div        <= DIV_W'(1);
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_brk_mark   <= 1'b0;
        end else begin
            r_frame_done <= w_last_stop_next & w_tick_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= in_data;
                        r_div      <= w_div_eff;
                        r_par      <= (^in_data) ^ (PARITY == PAR_ODD);
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end else if (w_brk) begin
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_brk_mark <= 1'b0;
                        r_state    <= S_BREAK;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    // Hold the line low while brk is high, then one mark bit
                    if (!r_brk_mark) begin
                        if (!w_brk) begin
                            r_tx       <= 1'b1;
                            r_brk_mark <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_brk_mark <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8-N-1, 7-E-2, 8-O-1) share one
// stimulus thread; a monitor pops expected frames and checks the tx waveform.
module tb_uart_tx_cfg;

    typedef struct {
        int          id;
        logic [15:0] bits;      // bit i = i-th transmitted bit
        int          nbits;
        int          div;
        int          abort_len; // 0 = complete frame, else expected busy cycles
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] cpb;
    logic [8:0]  din;
    logic [2:0]  vld;
    logic [2:0]  rdy_v;
    logic [2:0]  tx_v;
    logic [2:0]  busy_v;
    logic [2:0]  fd_v;
    logic        brk0;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   last_fd_cyc;
    int   gap_last;
    int   gap_rdy;
    int   idle_rdy;

    uart_tx_cfg u_d0 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .in_data(din[7:0]),
        .in_valid(vld[0]), .in_ready(rdy_v[0]),
`ifdef UART_TX_BREAK_EN
        .brk(brk0),
`endif
        .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0])
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d1 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .in_data(din[6:0]),
        .in_valid(vld[1]), .in_ready(rdy_v[1]),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1])
    );

    uart_tx_cfg #(.PARITY(2)) u_d2 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .in_data(din[7:0]),
        .in_valid(vld[2]), .in_ready(rdy_v[2]),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: detect frame start on any DUT, pop expectation, check waveform
    initial begin : monitor
        exp_t        e;
        logic [2:0]  busy_q;
        int          k;
        int          n;
        int          bad;
        int          fdn;
        int          fdpos;
        int          bi;
        busy_q = '0;
        forever begin
            @(negedge clk);
            k = -1;
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i] && !busy_q[i]) k = i;
            end
            if (k < 0) begin
                if (rdy_v[0]) idle_rdy++;
                busy_q = busy_v;
            end else begin
                gap_last = cyc - last_fd_cyc;
                gap_rdy  = idle_rdy;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", k, -1);
                    e = '{id: -1, bits: 16'h0, nbits: 1, div: 1, abort_len: -1};
                end else begin
                    e = exp_q.pop_front();
                end
                check("frame_dut", k, e.id);
                n = 0; bad = 0; fdn = 0; fdpos = -1;
                while (busy_v[k] && n < 400) begin
                    bi = n / e.div;
                    if (bi >= e.nbits || bi > 15) bad++;
                    else if (tx_v[k] !== e.bits[bi]) bad++;
                    if (fd_v[k]) begin
                        fdn++;
                        fdpos = n + 1;
                        last_fd_cyc = cyc;
                    end
                    n++;
                    @(negedge clk);
                end
                busy_q   = busy_v;
                idle_rdy = rdy_v[0] ? 1 : 0;
                check("tx_wave_bad_cycles", bad, 0);
                if (e.abort_len == 0) begin
                    check("frame_len", n, e.nbits * e.div);
                    check("done_count", fdn, 1);
                    check("done_pos", fdpos, n);
                    check("idle_tx", int'(tx_v[k]), 1);
                end else begin
                    check("abort_len", n, e.abort_len);
                    check("abort_no_done", fdn, 0);
                end
            end
        end
    end

    task automatic send(input int id, input logic [8:0] d, input logic [15:0] cpb_v,
                        input logic [15:0] bits, input int nbits, input int div,
                        input int abort_len, input bit keep_valid);
        int t;
        din     = d;
        cpb     = cpb_v;
        vld[id] = 1'b1;
        t = 0;
        while (!rdy_v[id] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("send_ready_timeout", t, 0);
        exp_q.push_back('{id: id, bits: bits, nbits: nbits, div: div, abort_len: abort_len});
        @(negedge clk);
        if (!keep_valid) vld[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy_v != 3'b000 || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("idle_timeout", t, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        checks = 0; errors = 0; cyc = 0; last_fd_cyc = 0;
        gap_last = 0; gap_rdy = 0; idle_rdy = 0;
        rst = 1'b1; cpb = 16'd4; din = '0; vld = '0; brk0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", int'(tx_v[i]), 1);
            check("rst_busy", int'(busy_v[i]), 0);
            check("rst_done", int'(fd_v[i]), 0);
            check("rst_ready", int'(rdy_v[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(rdy_v), 7);

        // 8-N-1, 0xA5, div 4: 0,1,0,1,0,0,1,0,1,1
        send(0, 9'h0A5, 16'd4, 16'h034A, 10, 4, 0, 1'b0);
        wait_idle();
        // 7-E-2, 0x55, div 3: data 1010101, parity 0, two stop bits
        send(1, 9'h055, 16'd3, 16'h06AA, 11, 3, 0, 1'b0);
        wait_idle();
        // 8-O-1: 0x00 -> parity 1, 0x01 -> parity 0
        send(2, 9'h000, 16'd2, 16'h0600, 11, 2, 0, 1'b0);
        wait_idle();
        send(2, 9'h001, 16'd2, 16'h0402, 11, 2, 0, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held high; data change while busy ignored
        send(0, 9'h001, 16'd2, 16'h0202, 10, 2, 0, 1'b1);
        send(0, 9'h080, 16'd2, 16'h0300, 10, 2, 0, 1'b0);
        wait_idle();
        check("b2b_idle_cycles", gap_last - 1, 1);
        check("b2b_ready_cycles", gap_rdy, 1);

        // Divisor 0 behaves as 1
        send(0, 9'h03C, 16'd0, 16'h0278, 10, 1, 0, 1'b0);
        wait_idle();
        // Divisor change mid-frame has no effect
        send(0, 9'h0C3, 16'd5, 16'h0386, 10, 5, 0, 1'b0);
        cpb = 16'd9;
        wait_idle();

`ifdef UART_TX_BREAK_EN
        // Break: 20 low cycles, then one mark bit at the last divisor (5)
        exp_q.push_back('{id: 0, bits: 16'h0010, nbits: 5, div: 5, abort_len: 25});
        brk0 = 1'b1;
        repeat (20) @(negedge clk);
        brk0 = 1'b0;
        wait_idle();
        check("brk_ready_after", int'(rdy_v[0]), 1);
`endif

        // Reset during DATA aborts the frame
        send(0, 9'h0FF, 16'd4, 16'h03FE, 10, 4, 11, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", int'(tx_v[0]), 1);
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_ready_in_rst", int'(rdy_v[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", int'(rdy_v[0]), 1);
        wait_idle();

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised 8-N-1 successor: UART transmitter with compile-time frame format (data bits, parity, stop bits) and a runtime baud divisor.
Accepts bytes over a valid/ready handshake and serialises them LSB first.
Sits between the byte producer (CPU/bus bridge, test pattern source) and the pad-level tx line.
Also reports busy and a one-cycle frame-done strobe.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, 0, parity mode; 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
DIV_W, 16, width of the runtime clocks-per-bit divisor.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
clks_per_bit  in  DIV_W  clocks per bit; sampled only at accept.
in_data  in  DATA_BITS  word to transmit.
in_valid  in  1  producer has a word.
in_ready  out  1  block can accept; transfer when in_valid & in_ready.
tx  out  1  serial line; idles high.
busy  out  1  high from the accept cycle+1 through the last stop-bit cycle.
frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset, checked at every clk edge while rst=1: tx=1, busy=0, frame_done=0, state=IDLE, counters=0.
- in_ready is combinational: (state==IDLE) & ~rst & ~brk. It is therefore 0 while rst=1.
- Reset mid-frame aborts immediately. tx=1 on the next edge; the partial frame is discarded.
- Accept happens at cycle N when in_valid & in_ready. Sample in_data into a shifter and clks_per_bit into a divisor register.
- Divisor value 0 is treated as 1. Changes to clks_per_bit mid-frame have no effect.
- States and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. The PARITY state exists only if PARITY != 0.
- tx=0 (start bit) from cycle N+1. Each bit is held exactly div clock cycles.
- DATA sends DATA_BITS bits, LSB first, using a bit index counter 0..DATA_BITS-1.
- Parity bit: even = XOR of the data bits; odd = inverted XOR. It is computed from the word latched at accept.
- STOP drives tx=1 for STOP_BITS*div cycles. frame_done=1 on its last cycle; the state returns to IDLE on the next edge.
- Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*div cycles. There is a minimum of 1 IDLE cycle between back-to-back frames. With in_valid held high, a new start bit begins exactly 1 cycle after the frame_done cycle.
- busy falls in the IDLE cycle following frame_done.
- in_data and in_valid changing while in_ready=0 are ignored.
- The bit-timing counter is DIV_W bits wide and cannot overflow: it reloads at div-1.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input port brk (1 bit).
- While in IDLE and brk=1: state becomes BREAK, tx=0, busy=1, in_ready=0.
- On brk falling, drive tx=1 for one bit time (div from the last sampled divisor, reset value 1) before returning to IDLE.
- brk asserted mid-frame is deferred until the frame completes.
- Not defined: no brk port, no BREAK state. Behaviour is as above with brk treated as 0.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK);
  - parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - the divisor-width default.
- One sub-module, uart_baud_tick: a loadable down-counter emitting a one-cycle tick every div cycles, restart on load. The FSM, shifter and parity logic stay in uart_tx_cfg.

Test Plan:
- Default 8-N-1, div=4, in_data=0xA5 single accept -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; frame_done at cycle 40 after accept; busy high 40 cycles.
- DATA_BITS=7, PARITY=1 (even), STOP_BITS=2, div=3, in_data=0x55 -> 7 data bits 1,0,1,0,1,0,1, parity 0, stop high 6 cycles; frame 33 cycles.
- PARITY=2 (odd), in_data=0x00 -> parity bit 1. Then in_data=0x01 -> parity bit 0.
- Back-to-back: in_valid held high with 0x01 then 0x80, div=2 -> second start bit begins 1 cycle after the first frame_done; in_ready high for exactly one cycle between frames.
- clks_per_bit=0 -> each bit 1 cycle wide. clks_per_bit changed 5->9 mid-frame -> frame still uses 5.
- rst pulsed in mid DATA -> next edge tx=1, busy=0, in_ready=1 after release. With UART_TX_BREAK_EN: brk high 20 cycles in IDLE -> tx low 20 cycles, then high div cycles, then in_ready=1.
